reconfig_dump_unit: RTL and testbench
=====================================

Name: reconfig_dump_unit

Overview:
UART-facing control unit for the debugger. It decodes host command bytes and streams instrumentation configuration bytes to the building blocks with per-block IDs. It also freezes tracing and dumps the valid trace-buffer entries byte-serially over UART. This generation adds synchronous reset, explicit command decoding, a configurable quiet period, a configurable memory read latency, partial dumps and an entry-count header.

Parameters:
N, 8, vector lanes per trace-buffer entry
TB_SIZE, 8, trace-buffer depth in entries (2..255)
DATA_WIDTH, 32, bits per lane (multiple of 8)
MAX_CHAINS, 4, firmware chains; sizes the config segments
SLEEP_CYCLES, 25000000, quiet cycles between the dump command and the first transmitted byte (>=0)
MEM_LATENCY, 2, cycles from tb_mem_address change to valid vector_out_tb (>=1)
CMD_CONFIG, 8'd42, host byte that starts reconfiguration
CMD_DUMP, 8'd68, host byte that starts a dump

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
rx_data  in  8  received UART byte
new_rx_data  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to transmit
new_tx_data  out  1  one-cycle transmit strobe
tx_busy  in  1  UART transmitter busy
tracing  out  1  high only in IDLE
configId  out  8  target block ID of configData
configData  out  8  configuration byte
config_valid  out  1  one-cycle strobe, configId/configData valid
tb_mem_address  out  $clog2(TB_SIZE)  trace-buffer read address
tb_valid_entries  in  $clog2(TB_SIZE)+1  entries currently written
vector_out_tb  in  N x DATA_WIDTH  trace-buffer read data, lane array [N-1:0]

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- State on reset:
  - state=IDLE.
  - All counters cleared.
  - new_tx_data=0, config_valid=0, tx_data=0, configId=0, configData=0, tb_mem_address=0.
  - tracing=1 on the first cycle after reset.
  - Reset mid-config or mid-dump aborts immediately. No partial byte strobe follows.
- States: IDLE, CONFIG, SLEEP, ADDR, MEM_WAIT, LOAD, SEND, WAIT_TX, NEXT.
- IDLE:
  - new_rx_data with CMD_CONFIG -> CONFIG.
  - new_rx_data with CMD_DUMP -> SLEEP.
  - Any other byte is ignored; stay in IDLE.
- CONFIG:
  - Segment lengths in byte order: ID0 (IB) 1 byte, ID1 (FRU) 3*MAX_CHAINS, ID2 (VVALU) 5*MAX_CHAINS, ID3 (VSRU) MAX_CHAINS, ID4 (DP) 2*MAX_CHAINS.
  - Total TOTAL_CFG = 1 + 11*MAX_CHAINS; must be <=255.
  - For each new_rx_data: on the next cycle configData=rx_data, configId=segment of the byte index (cumulative boundaries), config_valid=1 for exactly one cycle.
  - After the TOTAL_CFG-th byte strobe, return to IDLE on the following cycle.
  - Command-value bytes inside CONFIG are data, not commands.
- SLEEP: count SLEEP_CYCLES cycles, then -> ADDR with entry counter E=0.
  - E_MAX = min(tb_valid_entries, TB_SIZE), sampled on entry to SLEEP.
  - Header: before any entry data, one header byte = E_MAX[7:0] is sent through LOAD/SEND/WAIT_TX.
  - If E_MAX=0, only the header is sent, then -> IDLE.
- Entry read: ADDR drives tb_mem_address=E. MEM_WAIT holds MEM_LATENCY cycles. LOAD captures vector_out_tb into a shift register of width N*DATA_WIDTH.
- Byte order: lane 0 bits [7:0] are sent first, ascending through lane N-1 MSB. BYTES_PER_ENTRY = N*DATA_WIDTH/8.
- SEND:
  - tx_data = shift[7:0].
  - new_tx_data=1 for one cycle.
  - Next state WAIT_TX, which ignores tx_busy for its first cycle, then leaves when tx_busy==0.
- NEXT:
  - Not at the last byte of the entry: shift right 8 bits, -> SEND. No re-read.
  - Last byte and E<E_MAX-1: E++, -> ADDR.
  - Otherwise -> IDLE.
- new_rx_data during SLEEP..NEXT is ignored.
- tb_mem_address holds its last value in IDLE and CONFIG.

Optional Feature:
RECONFIG_DUMP_CHECKSUM_EN
- Defined: after the last data byte, one extra byte is transmitted, equal to the XOR of the header and all data bytes. It is sent with the same SEND/WAIT_TX handshake, then -> IDLE.
- Undefined: no trailer byte; the checksum register does not exist.

Test Plan:
1. Reset, then new_rx_data 8'h10 -> stays IDLE, tracing=1, no strobes.
2. MAX_CHAINS=4: CMD_CONFIG then 45 bytes 0..44 -> 45 config_valid pulses.
   - configId: 0 for byte 0, 1 for bytes 1-12, 2 for 13-32, 3 for 33-36, 4 for 37-44.
   - tracing returns to 1 afterwards.
3. SLEEP_CYCLES=10, N=2, DATA_WIDTH=16, tb_valid_entries=2, lane0=16'hA1B2, lane1=16'hC3D4 per entry, CMD_DUMP.
   - First new_tx_data occurs >=10 cycles after the command.
   - Bytes per entry: B2, A1, D4, C3. Bytes sent: 02, then that sequence twice; 9 bytes total (10 with checksum, trailer=02).
4. tb_valid_entries=0, CMD_DUMP -> single byte 00 (plus 00 checksum if enabled), back to IDLE.
5. tx_busy held high 50 cycles per byte -> exactly one new_tx_data per byte, no duplicates or drops.
6. Assert reset mid-dump after 3 bytes -> IDLE next cycle, new_tx_data=0; a fresh dump restarts from the header.

Source files
------------

// File: rtl/reconfig_dump_unit.sv
// Debugger UART control unit: decodes host commands, streams per-block configuration bytes, and dumps trace-buffer entries.
// Optional trailer: define RECONFIG_DUMP_CHECKSUM_EN to append an XOR checksum byte after each dump.
module reconfig_dump_unit #(
  parameter int         N            = 8,
  parameter int         TB_SIZE      = 8,
  parameter int         DATA_WIDTH   = 32,
  parameter int         MAX_CHAINS   = 4,
  parameter int         SLEEP_CYCLES = 25000000,
  parameter int         MEM_LATENCY  = 2,
  parameter logic [7:0] CMD_CONFIG   = 8'd42,
  parameter logic [7:0] CMD_DUMP     = 8'd68,
  localparam int        AW           = $clog2(TB_SIZE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     rx_data,
  input  logic                           new_rx_data,
  output logic [7:0]                     tx_data,
  output logic                           new_tx_data,
  input  logic                           tx_busy,
  output logic                           tracing,
  output logic [7:0]                     configId,
  output logic [7:0]                     configData,
  output logic                           config_valid,
  output logic [AW-1:0]                  tb_mem_address,
  input  logic [AW:0]                    tb_valid_entries,
  input  logic [N-1:0][DATA_WIDTH-1:0]   vector_out_tb
);

  localparam int SW  = N * DATA_WIDTH;
  localparam int BPE = SW / 8;
  localparam int BW  = $clog2(BPE + 1);
  localparam int SCW = (SLEEP_CYCLES < 1) ? 1 : $clog2(SLEEP_CYCLES + 1);
  localparam int MW  = $clog2(MEM_LATENCY + 1);
  localparam int EW  = AW + 1;

  // Cumulative segment boundaries (exclusive end index) for block IDs 0..3.
  localparam logic [7:0] SEG0_END = 8'(1);
  localparam logic [7:0] SEG1_END = 8'(1 + 3 * MAX_CHAINS);
  localparam logic [7:0] SEG2_END = 8'(1 + 8 * MAX_CHAINS);
  localparam logic [7:0] SEG3_END = 8'(1 + 9 * MAX_CHAINS);
  localparam logic [7:0] CFG_LAST = 8'(11 * MAX_CHAINS);

  localparam logic [SCW-1:0] SLEEP_LAST = SCW'(SLEEP_CYCLES);
  localparam logic [MW-1:0]  MEM_LAST   = MW'(MEM_LATENCY - 1);
  localparam logic [BW-1:0]  BYTE_LAST  = BW'(BPE - 1);
  localparam logic [EW-1:0]  TB_MAX     = EW'(TB_SIZE);

  typedef enum logic [3:0] {
    ST_IDLE, ST_CONFIG, ST_SLEEP, ST_ADDR, ST_MEM_WAIT,
    ST_LOAD, ST_SEND, ST_WAIT_TX, ST_NEXT
  } state_t;

  state_t          state;
  logic [7:0]      cfg_cnt;
  logic            cfg_done;
  logic [SCW-1:0]  sleep_cnt;
  logic [MW-1:0]   mem_cnt;
  logic [BW-1:0]   byte_cnt;
  logic [EW-1:0]   entry;
  logic [EW-1:0]   e_max;
  logic            hdr_phase;
  logic            tx_first;
  logic [SW-1:0]   shift;
`ifdef RECONFIG_DUMP_CHECKSUM_EN
  logic [7:0]      csum;
  logic            csum_phase;
`endif

  function automatic logic [7:0] seg_id(input logic [7:0] idx);
    if (idx < SEG0_END)      return 8'd0;
    else if (idx < SEG1_END) return 8'd1;
    else if (idx < SEG2_END) return 8'd2;
    else if (idx < SEG3_END) return 8'd3;
    else                     return 8'd4;
  endfunction

  assign tracing = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cfg_cnt        <= '0;
      cfg_done       <= 1'b0;
      sleep_cnt      <= '0;
      mem_cnt        <= '0;
      byte_cnt       <= '0;
      entry          <= '0;
      e_max          <= '0;
      hdr_phase      <= 1'b0;
      tx_first       <= 1'b0;
      shift          <= '0;
      tx_data        <= '0;
      new_tx_data    <= 1'b0;
      configId       <= '0;
      configData     <= '0;
      config_valid   <= 1'b0;
      tb_mem_address <= '0;
`ifdef RECONFIG_DUMP_CHECKSUM_EN
      csum           <= '0;
      csum_phase     <= 1'b0;
`endif
    end else begin
      new_tx_data  <= 1'b0;
      config_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (new_rx_data) begin
            if (rx_data == CMD_CONFIG) begin
              state    <= ST_CONFIG;
              cfg_cnt  <= '0;
              cfg_done <= 1'b0;
            end else if (rx_data == CMD_DUMP) begin
              state     <= ST_SLEEP;
              sleep_cnt <= '0;
              entry     <= '0;
              hdr_phase <= 1'b1;
              e_max     <= (tb_valid_entries > TB_MAX) ? TB_MAX : tb_valid_entries;
`ifdef RECONFIG_DUMP_CHECKSUM_EN
              csum       <= '0;
              csum_phase <= 1'b0;
`endif
            end
          end
        end
        ST_CONFIG: begin
          // Every byte here is payload, including ones equal to a command value.
          if (cfg_done) begin
            state <= ST_IDLE;
          end else if (new_rx_data) begin
            config_valid <= 1'b1;
            configData   <= rx_data;
            configId     <= seg_id(cfg_cnt);
            cfg_cnt      <= cfg_cnt + 8'd1;
            if (cfg_cnt == CFG_LAST) cfg_done <= 1'b1;
          end
        end
        ST_SLEEP: begin
          // The header byte goes out first, so the quiet period leads straight to LOAD.
          if (sleep_cnt == SLEEP_LAST) state <= ST_LOAD;
          else                         sleep_cnt <= sleep_cnt + 1'b1;
        end
        ST_ADDR: begin
          tb_mem_address <= entry[AW-1:0];
          mem_cnt        <= '0;
          state          <= ST_MEM_WAIT;
        end
        ST_MEM_WAIT: begin
          if (mem_cnt == MEM_LAST) state <= ST_LOAD;
          else                     mem_cnt <= mem_cnt + 1'b1;
        end
        ST_LOAD: begin
          byte_cnt <= '0;
          state    <= ST_SEND;
          if (hdr_phase)       shift <= SW'(8'(e_max));
`ifdef RECONFIG_DUMP_CHECKSUM_EN
          else if (csum_phase) shift <= SW'(csum);
`endif
          else                 shift <= vector_out_tb;
        end
        ST_SEND: begin
          tx_data     <= shift[7:0];
          new_tx_data <= 1'b1;
          tx_first    <= 1'b1;
          state       <= ST_WAIT_TX;
`ifdef RECONFIG_DUMP_CHECKSUM_EN
          csum        <= csum ^ shift[7:0];
`endif
        end
        ST_WAIT_TX: begin
          // The transmitter raises busy a cycle after the strobe, so skip the first look.
          if (tx_first)      tx_first <= 1'b0;
          else if (!tx_busy) state    <= ST_NEXT;
        end
        ST_NEXT: begin
          if (hdr_phase) begin
            hdr_phase <= 1'b0;
            if (e_max == '0) begin
`ifdef RECONFIG_DUMP_CHECKSUM_EN
              csum_phase <= 1'b1;
              state      <= ST_LOAD;
`else
              state      <= ST_IDLE;
`endif
            end else begin
              state <= ST_ADDR;
            end
          end
`ifdef RECONFIG_DUMP_CHECKSUM_EN
          else if (csum_phase) begin
            csum_phase <= 1'b0;
            state      <= ST_IDLE;
          end
`endif
          else if (byte_cnt != BYTE_LAST) begin
            shift    <= shift >> 8;
            byte_cnt <= byte_cnt + 1'b1;
            state    <= ST_SEND;
          end else if ((entry + EW'(1)) < e_max) begin
            entry <= entry + EW'(1);
            state <= ST_ADDR;
          end else begin
`ifdef RECONFIG_DUMP_CHECKSUM_EN
            csum_phase <= 1'b1;
            state      <= ST_LOAD;
`else
            state      <= ST_IDLE;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reconfig_dump_unit.sv
// Directed bench for reconfig_dump_unit: config streaming, dumps (header, clamp, empty, busy), and mid-dump reset.
module tb_reconfig_dump_unit;
  localparam int N = 2, TB_SIZE = 8, DW = 16, MC = 4, SLEEP = 10, LAT = 2, AW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic new_rx_data = 1'b0;
  logic [7:0] tx_data;
  logic new_tx_data;
  logic tx_busy = 1'b0;
  logic tracing;
  logic [7:0] configId, configData;
  logic config_valid;
  logic [AW-1:0] tb_mem_address;
  logic [AW:0] tb_valid_entries = '0;
  logic [N-1:0][DW-1:0] vector_out_tb = '0;

  logic [N-1:0][DW-1:0] mem [TB_SIZE];
  logic [N-1:0][DW-1:0] mem_d1 = '0;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, first_tx_cyc = -1, cmd_cyc = 0;
  int busy_len = 0, busy_cnt = 0;
  logic [7:0]  tx_q[$];
  logic [15:0] cfg_q[$];
  logic [7:0]  exp_q[$];

  reconfig_dump_unit #(
    .N(N), .TB_SIZE(TB_SIZE), .DATA_WIDTH(DW), .MAX_CHAINS(MC),
    .SLEEP_CYCLES(SLEEP), .MEM_LATENCY(LAT), .CMD_CONFIG(8'd42), .CMD_DUMP(8'd68)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .tracing(tracing), .configId(configId), .configData(configData),
    .config_valid(config_valid), .tb_mem_address(tb_mem_address),
    .tb_valid_entries(tb_valid_entries), .vector_out_tb(vector_out_tb)
  );

  // Clock and two-stage read pipeline modelling MEM_LATENCY=2.
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc           <= cyc + 1;
    mem_d1        <= mem[tb_mem_address];
    vector_out_tb <= mem_d1;
  end

  // Monitor plus a transmitter that stays busy busy_len cycles after each strobe.
  always @(negedge clk) begin
    if (new_tx_data) begin
      tx_q.push_back(tx_data);
      if (first_tx_cyc < 0) first_tx_cyc = cyc;
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    tx_busy = (busy_cnt > 0);
    if (config_valid) cfg_q.push_back({configId, configData});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (tracing !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle_in_time"}, (k < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic add_csum();
`ifdef RECONFIG_DUMP_CHECKSUM_EN
    logic [7:0] x = '0;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
`endif
  endtask

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_count"}, tx_q.size(), exp_q.size());
    n = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), tx_q[i], exp_q[i]);
  endtask

  task automatic dump(input logic [AW:0] entries);
    tb_valid_entries = entries;
    tx_q.delete();
    exp_q.delete();
    first_tx_cyc = -1;
    cmd_cyc = cyc;
    send_byte(8'd68);
  endtask

  initial begin
    logic [7:0] exp_id;
    for (int i = 0; i < TB_SIZE; i++) mem[i] = {16'hC3D4, 16'hA1B2};

    // Reset values
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_tracing", tracing, 1);
    check("rst_new_tx", new_tx_data, 0);
    check("rst_cfg_valid", config_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_cfg_id", configId, 0);
    check("rst_cfg_data", configData, 0);
    check("rst_addr", tb_mem_address, 0);

    // Unknown command byte is ignored
    send_byte(8'h10);
    repeat (5) @(negedge clk);
    check("ign_tracing", tracing, 1);
    check("ign_cfg_strobes", cfg_q.size(), 0);
    check("ign_tx_strobes", tx_q.size(), 0);

    // Configuration: 45 bytes with segment IDs
    send_byte(8'd42);
    check("cfg_tracing_low", tracing, 0);
    for (int b = 0; b < 45; b++) send_byte(8'(b));
    repeat (4) @(negedge clk);
    check("cfg_count", cfg_q.size(), 45);
    for (int b = 0; b < 45 && b < cfg_q.size(); b++) begin
      exp_id = (b == 0) ? 8'd0 : (b <= 12) ? 8'd1 : (b <= 32) ? 8'd2 : (b <= 36) ? 8'd3 : 8'd4;
      check($sformatf("cfg_id%0d", b), cfg_q[b][15:8], exp_id);
      check($sformatf("cfg_data%0d", b), cfg_q[b][7:0], b);
    end
    check("cfg_tracing_back", tracing, 1);

    // Dump of two identical entries
    dump(4'd2);
    check("dump_tracing_low", tracing, 0);
    wait_idle("dump2", 1000);
    exp_q = '{8'h02, 8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'hD4, 8'hC3};
    add_csum();
    check_stream("dump2");
    check("quiet_period", (first_tx_cyc - cmd_cyc) >= SLEEP, 1);

    // Empty buffer: header only
    dump(4'd0);
    wait_idle("dump0", 500);
    exp_q = '{8'h00};
    add_csum();
    check_stream("dump0");

    // Entry count above depth is clamped; distinct data per address
    for (int i = 0; i < TB_SIZE; i++)
      mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    dump(4'd9);
    wait_idle("clamp", 3000);
    exp_q.push_back(8'h08);
    for (int b = 0; b < 32; b++) exp_q.push_back(8'(b));
    add_csum();
    check_stream("clamp");

    // Slow transmitter: exactly one strobe per byte
    busy_len = 50;
    dump(4'd1);
    wait_idle("busy", 3000);
    exp_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03};
    add_csum();
    check_stream("busy");

    // Reset after three bytes aborts, then a fresh dump restarts from the header
    busy_len = 5;
    dump(4'd2);
    begin
      int k = 0;
      while (tx_q.size() < 3 && k < 500) begin
        @(negedge clk);
        k++;
      end
      check("abort_reach_3", (k < 500), 1);
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_tracing", tracing, 1);
    check("abort_new_tx", new_tx_data, 0);
    check("abort_addr", tb_mem_address, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_more_bytes", tx_q.size(), 3);
    check("abort_still_idle", tracing, 1);

    dump(4'd2);
    wait_idle("restart", 2000);
    exp_q = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    add_csum();
    check_stream("restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop if the directed sequence stalls somewhere unexpected.
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
